// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ready bus between the fetch stage and imem.
// imem_data is valid for the imem_addr of the same cycle when imem_ready=1.
interface fetch_stage_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_data
    );
endinterface

// File: rtl/fetch_stage.sv
// IF stage of the 16-bit pipeline: owns the PC, talks to imem and
// feeds the IF/ID register, with stall buffering, redirects and HLT.
module fetch_stage #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [15:0]          redirect_pc,
    fetch_stage_if.master        imem_bus,
    output logic                 ifid_en,
    output logic [15:0]          instr,
    output logic [15:0]          nextpc,
    output logic                 flush,
    output logic                 halted,
    output logic [15:0]          pc
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] pc_nxt;
    logic [15:0] hold_instr;
    logic [15:0] hold_nxt;
    logic [15:0] pc_inc;

    assign pc_inc = pc + 16'd2;
    assign imem_bus.imem_addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            state      <= FETCH;
            hold_instr <= 16'h0000;
        end else begin
            pc         <= pc_nxt;
            state      <= state_nxt;
            hold_instr <= hold_nxt;
        end
    end

    always_comb begin
        imem_bus.imem_req = 1'b0;
        ifid_en           = 1'b0;
        instr             = 16'h0000;
        nextpc            = 16'h0000;
        flush             = 1'b0;
        halted            = 1'b0;
        pc_nxt            = pc;
        state_nxt         = state;
        hold_nxt          = hold_instr;

        if (rst) begin
            state_nxt = FETCH;
        end else if (redirect) begin
            // Bubble into IF/ID; anything returned or held is dropped.
            flush     = 1'b1;
            ifid_en   = 1'b1;
            pc_nxt    = redirect_pc;
            state_nxt = FETCH;
        end else begin
            unique case (state)
                FETCH: begin
                    imem_bus.imem_req = 1'b1;
                    if (imem_bus.imem_ready && !stall) begin
                        ifid_en = 1'b1;
                        instr   = imem_bus.imem_data;
                        nextpc  = pc_inc;
                        if (imem_bus.imem_data[15:12] == HALT_OPCODE) begin
                            state_nxt = HALTED;
                        end else begin
                            pc_nxt = pc_inc;
                        end
                    end else if (imem_bus.imem_ready) begin
                        hold_nxt  = imem_bus.imem_data;
                        state_nxt = HOLD;
                    end
                end
                HOLD: begin
                    instr  = hold_instr;
                    nextpc = pc_inc;
                    if (!stall) begin
                        ifid_en = 1'b1;
                        if (hold_instr[15:12] == HALT_OPCODE) begin
                            state_nxt = HALTED;
                        end else begin
                            pc_nxt    = pc_inc;
                            state_nxt = FETCH;
                        end
                    end
                end
                HALTED: begin
                    halted  = 1'b1;
                    ifid_en = 1'b1;
                end
                default: begin
                    state_nxt = FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run
// against a buffer/halt-flag model of the fetch rules.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        ifid_en;
    logic [15:0] instr;
    logic [15:0] nextpc;
    logic        flush;
    logic        halted;
    logic [15:0] pc;

    int n_pass  = 0;
    int n_total = 0;

    fetch_stage_if imem_bus ();

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_bus    (imem_bus.master),
        .ifid_en     (ifid_en),
        .instr       (instr),
        .nextpc      (nextpc),
        .flush       (flush),
        .halted      (halted),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic r, input logic st, input logic rd,
                       input logic [15:0] rpc, input logic rdy,
                       input logic [15:0] d);
        @(negedge clk);
        rst                 = r;
        stall               = st;
        redirect            = rd;
        redirect_pc         = rpc;
        imem_bus.imem_ready = rdy;
        imem_bus.imem_data  = d;
        #1;
    endtask

    task automatic test_reset();
        cyc(1, 0, 0, 16'h0, 1, 16'h1234);
        n_total++;
        if ({imem_bus.imem_req, ifid_en, flush, halted, instr, nextpc}
            !== 36'h0)
            $display("FAIL reset_outs req=%b en=%b fl=%b h=%b i=%h n=%h want 0",
                imem_bus.imem_req, ifid_en, flush, halted, instr, nextpc);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 16'h0, 1, 16'h1234);
            n_total++;
            if (imem_bus.imem_addr !== 16'(2 * i) || imem_bus.imem_req !== 1'b1
                || ifid_en !== 1'b1 || nextpc !== 16'(2 * i + 2)
                || instr !== 16'h1234)
                $display("FAIL seq_fetch%0d addr=%h req=%b en=%b n=%h i=%h want addr=%h n=%h",
                    i, imem_bus.imem_addr, imem_bus.imem_req, ifid_en, nextpc,
                    instr, 16'(2 * i), 16'(2 * i + 2));
            else n_pass++;
        end
    endtask

    task automatic test_wait();
        cyc(0, 0, 1, 16'h0010, 0, 16'h0);
        n_total++;
        if (flush !== 1'b1 || ifid_en !== 1'b1 || instr !== 16'h0
            || imem_bus.imem_req !== 1'b0)
            $display("FAIL redirect_bubble fl=%b en=%b i=%h req=%b want 1 1 0000 0",
                flush, ifid_en, instr, imem_bus.imem_req);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 16'h0, 0, 16'hDEAD);
            n_total++;
            if (imem_bus.imem_addr !== 16'h0010 || ifid_en !== 1'b0
                || imem_bus.imem_req !== 1'b1)
                $display("FAIL wait_hold addr=%h en=%b req=%b want 0010 0 1",
                    imem_bus.imem_addr, ifid_en, imem_bus.imem_req);
            else n_pass++;
        end
        cyc(0, 0, 0, 16'h0, 1, 16'h5678);
        n_total++;
        if (ifid_en !== 1'b1 || instr !== 16'h5678 || nextpc !== 16'h0012)
            $display("FAIL wait_accept en=%b i=%h n=%h want 1 5678 0012",
                ifid_en, instr, nextpc);
        else n_pass++;
        cyc(0, 0, 0, 16'h0, 0, 16'h0);
        n_total++;
        if (imem_bus.imem_addr !== 16'h0012)
            $display("FAIL wait_next addr=%h want 0012", imem_bus.imem_addr);
        else n_pass++;
    endtask

    task automatic test_stall_hold();
        cyc(0, 0, 1, 16'h0010, 0, 16'h0);
        cyc(0, 1, 0, 16'h0, 1, 16'hABCD);
        n_total++;
        if (ifid_en !== 1'b0 || imem_bus.imem_req !== 1'b1)
            $display("FAIL stall_capture en=%b req=%b want 0 1",
                ifid_en, imem_bus.imem_req);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            cyc(0, 1, 0, 16'h0, 1, 16'(i + 16'h0777));
            n_total++;
            if (imem_bus.imem_req !== 1'b0 || ifid_en !== 1'b0)
                $display("FAIL stall_hold req=%b en=%b want 0 0",
                    imem_bus.imem_req, ifid_en);
            else n_pass++;
        end
        cyc(0, 0, 0, 16'h0, 1, 16'h0999);
        n_total++;
        if (instr !== 16'hABCD || ifid_en !== 1'b1 || pc !== 16'h0010
            || nextpc !== 16'h0012)
            $display("FAIL hold_release i=%h en=%b pc=%h n=%h want ABCD 1 0010 0012",
                instr, ifid_en, pc, nextpc);
        else n_pass++;
        cyc(0, 0, 0, 16'h0, 0, 16'h0);
        n_total++;
        if (pc !== 16'h0012 || imem_bus.imem_req !== 1'b1)
            $display("FAIL hold_refetch pc=%h req=%b want 0012 1",
                pc, imem_bus.imem_req);
        else n_pass++;
    endtask

    task automatic test_redirect_hold();
        cyc(0, 0, 1, 16'h0010, 0, 16'h0);
        cyc(0, 1, 0, 16'h0, 1, 16'h1111);
        cyc(0, 1, 1, 16'h0100, 1, 16'h2222);
        n_total++;
        if (flush !== 1'b1 || ifid_en !== 1'b1 || instr !== 16'h0
            || nextpc !== 16'h0)
            $display("FAIL redir_stall fl=%b en=%b i=%h n=%h want 1 1 0000 0000",
                flush, ifid_en, instr, nextpc);
        else n_pass++;
        cyc(0, 0, 0, 16'h0, 0, 16'h0);
        n_total++;
        if (imem_bus.imem_addr !== 16'h0100 || imem_bus.imem_req !== 1'b1
            || flush !== 1'b0)
            $display("FAIL redir_target addr=%h req=%b fl=%b want 0100 1 0",
                imem_bus.imem_addr, imem_bus.imem_req, flush);
        else n_pass++;
    endtask

    task automatic test_halt();
        cyc(0, 0, 1, 16'h0020, 0, 16'h0);
        cyc(0, 0, 0, 16'h0, 1, 16'hF000);
        n_total++;
        if (ifid_en !== 1'b1 || instr !== 16'hF000 || halted !== 1'b0)
            $display("FAIL hlt_issue en=%b i=%h h=%b want 1 F000 0",
                ifid_en, instr, halted);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 0, 16'h0, 1, 16'h1234);
            n_total++;
            if (halted !== 1'b1 || pc !== 16'h0020 || imem_bus.imem_req !== 1'b0
                || instr !== 16'h0 || ifid_en !== 1'b1 || nextpc !== 16'h0)
                $display("FAIL halted h=%b pc=%h req=%b i=%h en=%b want 1 0020 0 0000 1",
                    halted, pc, imem_bus.imem_req, instr, ifid_en);
            else n_pass++;
        end
        cyc(0, 0, 1, 16'h0040, 1, 16'h0);
        n_total++;
        if (halted !== 1'b0 || flush !== 1'b1)
            $display("FAIL halt_exit h=%b fl=%b want 0 1", halted, flush);
        else n_pass++;
        cyc(0, 0, 0, 16'h0, 0, 16'h0);
        n_total++;
        if (imem_bus.imem_addr !== 16'h0040 || imem_bus.imem_req !== 1'b1
            || halted !== 1'b0)
            $display("FAIL halt_refetch addr=%h req=%b h=%b want 0040 1 0",
                imem_bus.imem_addr, imem_bus.imem_req, halted);
        else n_pass++;
    endtask

    task automatic test_wrap();
        cyc(0, 0, 1, 16'hFFFE, 0, 16'h0);
        cyc(0, 0, 0, 16'h0, 1, 16'h1234);
        n_total++;
        if (nextpc !== 16'h0000 || imem_bus.imem_addr !== 16'hFFFE)
            $display("FAIL wrap_nextpc n=%h addr=%h want 0000 FFFE",
                nextpc, imem_bus.imem_addr);
        else n_pass++;
        cyc(0, 0, 0, 16'h0, 0, 16'h0);
        n_total++;
        if (pc !== 16'h0000)
            $display("FAIL wrap_pc pc=%h want 0000", pc);
        else n_pass++;
    endtask

    // Model: an optional buffered word and a halted flag on top of pc.
    task automatic test_random();
        logic [15:0] m_pc = 16'h0;
        logic        m_buf_v = 1'b0;
        logic [15:0] m_buf = 16'h0;
        logic        m_halt = 1'b0;
        logic        e_req, e_en, e_fl, e_h;
        logic [15:0] e_i, e_n, issue;
        logic        do_issue;
        logic        r, st, rd, rdy;
        logic [15:0] rpc, d;
        int          errs;
        for (int k = 0; k < 600; k++) begin
            r   = (k == 0) || ($urandom_range(0, 49) == 0);
            st  = ($urandom_range(0, 2) == 0);
            rd  = ($urandom_range(0, 11) == 0);
            rpc = 16'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            d   = 16'($urandom);
            cyc(r, st, rd, rpc, rdy, d);
            {e_req, e_en, e_fl, e_h} = 4'b0;
            e_i = 16'h0;
            e_n = 16'h0;
            do_issue = 1'b0;
            issue = 16'h0;
            if (r) begin
            end else if (rd) begin
                e_en = 1'b1;
                e_fl = 1'b1;
            end else if (m_halt) begin
                e_h  = 1'b1;
                e_en = 1'b1;
            end else if (m_buf_v) begin
                e_i = m_buf;
                e_n = m_pc + 16'd2;
                if (!st) begin
                    e_en = 1'b1;
                    do_issue = 1'b1;
                    issue = m_buf;
                end
            end else begin
                e_req = 1'b1;
                if (rdy && !st) begin
                    e_en = 1'b1;
                    e_i  = d;
                    e_n  = m_pc + 16'd2;
                    do_issue = 1'b1;
                    issue = d;
                end
            end
            errs = 0;
            if (imem_bus.imem_req !== e_req || ifid_en !== e_en
                || flush !== e_fl || halted !== e_h || instr !== e_i
                || nextpc !== e_n)
                errs++;
            if (!r && (pc !== m_pc || imem_bus.imem_addr !== m_pc))
                errs++;
            n_total++;
            if (errs != 0)
                $display("FAIL rand%0d req=%b en=%b fl=%b h=%b i=%h n=%h pc=%h want %b %b %b %b %h %h %h",
                    k, imem_bus.imem_req, ifid_en, flush, halted, instr, nextpc,
                    pc, e_req, e_en, e_fl, e_h, e_i, e_n, m_pc);
            else n_pass++;
            if (r) begin
                m_pc = 16'h0;
                m_buf_v = 1'b0;
                m_buf = 16'h0;
                m_halt = 1'b0;
            end else if (rd) begin
                m_pc = rpc;
                m_buf_v = 1'b0;
                m_halt = 1'b0;
            end else if (do_issue) begin
                m_buf_v = 1'b0;
                if (issue[15:12] == 4'hF) m_halt = 1'b1;
                else m_pc = m_pc + 16'd2;
            end else if (!m_halt && !m_buf_v && rdy && st) begin
                m_buf_v = 1'b1;
                m_buf = d;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 16'h0;
        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_data = 16'h0;
        test_reset();
        test_wait();
        test_stall_hold();
        test_redirect_hold();
        test_halt();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
